// File: rtl/quad_enc_emu.sv
// quad_enc_emu: quadrature encoder emulator.
//
// On an accepted load the block walks an emulated shaft from its current
// position to a two-digit BCD target. It emits A/B quadrature edges, one every
// STEP_DIV clocks, and four edges make one detent. bcd_pos steps by one
// detent on the clock of the fourth edge, so {a,b} is 00 at every detent.
//
// Parameters:
//   STEP_DIV    clocks between successive quadrature edges (1..65535)
//
// Optional build macro:
//   ENC_WRAP_EN defined   -> shortest modulo-100 path, 99<->00 wrap,
//                            a tie at distance 50 goes CW
//   ENC_WRAP_EN undefined -> CW when target > bcd_pos, else CCW, never wraps
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   load        in   move request, sampled every clk (honoured only in IDLE)
//   bcd_target  in   [7:4] tens, [3:0] units target position
//   a, b        out  quadrature channels (CW: A leads B, CCW: B leads A)
//   bcd_pos     out  current emulated position, two BCD digits
//   busy        out  high while a move is in progress
//   done        out  one-cycle pulse when a move completes
//   err         out  one-cycle pulse when a load has a non-BCD digit
//   state_dbg   out  FSM state encoding (0 IDLE, 1 RUN, 2 FIN)
//
// Handshake: load is a level request with no ready. A load seen in IDLE is
// consumed on that edge. A load seen in RUN or FIN is dropped silently.
module quad_enc_emu #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] bcd_target,
  output logic       a,
  output logic       b,
  output logic [7:0] bcd_pos,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  state_t      state;
  logic [15:0] div;
  logic [1:0]  phase;     // 0..3 position within the current detent
  logic [7:0]  target;
  logic        dir_cw;

  logic        tgt_valid;
  logic        load_cw;
  logic [1:0]  next_phase;
  logic [7:0]  next_pos;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  // Phase 0..3 maps to {a,b} = 00,10,11,01. Incrementing the phase walks the
  // CW order and decrementing it walks the CCW order.
  function automatic logic [1:0] phase_ab(input logic [1:0] p);
    logic [1:0] r;
    case (p)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

`ifdef ENC_WRAP_EN
  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
  endfunction

  logic [7:0] pos_bin;
  logic [7:0] tgt_bin;
  logic [7:0] cw_dist;

  always_comb begin
    pos_bin = bcd_to_bin(bcd_pos);
    tgt_bin = bcd_to_bin(bcd_target);
    cw_dist = (tgt_bin >= pos_bin) ? (tgt_bin - pos_bin)
                                   : (tgt_bin + 8'd100 - pos_bin);
    // A distance of exactly 50 is a tie and resolves CW.
    load_cw = (cw_dist <= 8'd50);
  end
`else
  // For valid BCD, comparing the packed digits as unsigned gives numeric order.
  always_comb begin
    load_cw = (bcd_target > bcd_pos);
  end
`endif

  always_comb begin
    tgt_valid  = (bcd_target[7:4] <= 4'd9) && (bcd_target[3:0] <= 4'd9);
    next_phase = dir_cw ? phase + 2'd1 : phase - 2'd1;
    next_pos   = dir_cw ? bcd_inc(bcd_pos) : bcd_dec(bcd_pos);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div     <= 16'd0;
      phase   <= 2'd0;
      target  <= 8'h00;
      dir_cw  <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      bcd_pos <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (!tgt_valid) begin
              err <= 1'b1;
            end else if (bcd_target == bcd_pos) begin
              state <= FIN;
            end else begin
              target <= bcd_target;
              dir_cw <= load_cw;
              div    <= 16'd0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          // The divider starts at 0 on the accept edge, so the first edge
          // lands STEP_DIV clocks later.
          if (div == DIV_LAST) begin
            div    <= 16'd0;
            phase  <= next_phase;
            {a, b} <= phase_ab(next_phase);
            // Returning to phase 0 completes a detent.
            if (next_phase == 2'd0) begin
              bcd_pos <= next_pos;
              if (next_pos == target) begin
                state <= FIN;
              end
            end
          end else begin
            div <= div + 16'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_quad_enc_emu.sv
// tb_quad_enc_emu: directed bench for quad_enc_emu with STEP_DIV=2.
// Each expected quadrature edge is pushed to exp_q when a move is loaded. An
// edge is stored as {cycle, a, b, bcd_pos}. A negedge monitor pops and
// compares one entry each time {a,b} changes.
module tb_quad_enc_emu;

  localparam int SD = 2;
  localparam int W  = 42;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] bcd_target;
  logic       a, b;
  logic [7:0] bcd_pos;
  logic       busy, done, err;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  int           mpos = 0;
  logic [1:0]   prev_ab = 2'b00;
  logic [7:0]   prev_pos = 8'h00;

  logic [1:0] cw_ab[4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ccw_ab[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_enc_emu #(.STEP_DIV(SD)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_target(bcd_target),
    .a(a), .b(b), .bcd_pos(bcd_pos), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int p);
    return 8'(((p / 10) << 4) | (p % 10));
  endfunction

  // Edge monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ab  = {a, b};
      prev_pos = bcd_pos;
    end else begin
      if (done) done_cnt++;
      if ({a, b} !== prev_ab) begin
        logic [W-1:0] want;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : {W{1'b1}};
        check("edge", {32'(cyc), a, b, bcd_pos}, want);
      end else if (bcd_pos !== prev_pos) begin
        check("pos_without_edge", bcd_pos, prev_pos);
      end
      prev_ab  = {a, b};
      prev_pos = bcd_pos;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Model the move: pick a direction and detent count, then queue every edge.
  task automatic push_move(input logic [7:0] tgt, output int n, output int acc);
    int  t;
    bit  cw;
    t = int'(tgt[7:4]) * 10 + int'(tgt[3:0]);
`ifdef ENC_WRAP_EN
    begin
      int dcw;
      dcw = (t - mpos + 100) % 100;
      cw  = (dcw <= 50);
      n   = cw ? dcw : 100 - dcw;
    end
`else
    cw = (t > mpos);
    n  = cw ? t - mpos : mpos - t;
`endif
    acc = cyc + 1;
    for (int k = 1; k <= 4 * n; k++) begin
      if (k % 4 == 0) mpos = cw ? (mpos + 1) % 100 : (mpos + 99) % 100;
      exp_q.push_back({32'(acc + k * SD), cw ? cw_ab[(k - 1) % 4] : ccw_ab[(k - 1) % 4],
                       to_bcd(mpos)});
    end
  endtask

  // Drive a move and check busy, done timing, the final position and the
  // single done pulse.
  task automatic do_move(input logic [7:0] tgt);
    int n, acc, d0, cnt;
    d0 = done_cnt;
    load = 1'b1;
    bcd_target = tgt;
    push_move(tgt, n, acc);
    step();
    load = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    cnt = 0;
    while (!done && cnt < 4 * n * SD + 10) begin
      step();
      cnt++;
    end
    check("done_seen", done, 1'b1);
    check("done_cycle", 64'(cyc), 64'(acc + 4 * n * SD + 1));
    check("busy_at_done", busy, 1'b0);
    check("pos_at_done", bcd_pos, to_bcd(mpos));
    check("edges_consumed", 64'(exp_q.size()), 64'd0);
    step();
    check("done_one_cycle", done, 1'b0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int n, acc, d0;
    reset_n = 1'b0;
    load = 1'b0;
    bcd_target = 8'h00;

    // Reset values
    step();
    check("rst_ab", {a, b}, 2'b00);
    check("rst_pos", bcd_pos, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    step();
    reset_n = 1'b1;

    // Load on the first edge after reset: 00 -> 03 CW
    do_move(8'h03);
    // 03 -> 00 CCW, B leading A
    do_move(8'h00);

    // Invalid digit: err pulse only
    d0 = done_cnt;
    load = 1'b1;
    bcd_target = 8'h1A;
    step();
    load = 1'b0;
    check("err_pulse", err, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_pos", bcd_pos, 8'h00);
    step();
    check("err_one_cycle", err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("err_busy_stays_low", busy, 1'b0);
    end
    check("err_no_edges", {a, b}, 2'b00);
    check("err_no_done", 64'(done_cnt - d0), 64'd0);

    // 00 -> 98: wrap build goes CCW by 2, otherwise CW by 98
    do_move(8'h98);
    // Reach 05, then load 05 again
    do_move(8'h05);
    d0 = done_cnt;
    load = 1'b1;
    bcd_target = 8'h05;
    step();
    load = 1'b0;
    check("same_busy0", busy, 1'b0);
    check("same_done_not_yet", done, 1'b0);
    step();
    check("same_done", done, 1'b1);
    check("same_busy1", busy, 1'b0);
    step();
    check("same_done_one_cycle", done, 1'b0);
    check("same_pos", bcd_pos, 8'h05);
    check("same_done_count", 64'(done_cnt - d0), 64'd1);

    // Move to 20, with a load to 00 mid-move that must be ignored, then an
    // asynchronous reset mid-move.
    d0 = done_cnt;
    load = 1'b1;
    bcd_target = 8'h20;
    push_move(8'h20, n, acc);
    step();
    load = 1'b0;
    repeat (9) step();
    load = 1'b1;
    bcd_target = 8'h00;
    step();
    load = 1'b0;
    check("ignored_load_no_err", err, 1'b0);
    check("ignored_load_busy", busy, 1'b1);
    while (cyc < acc + 30) step();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ab", {a, b}, 2'b00);
    check("async_rst_pos", bcd_pos, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    mpos = 0;
    step();
    step();
    reset_n = 1'b1;
    repeat (4 * n * SD + 4) step();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_pos", bcd_pos, 8'h00);
    check("abort_no_edges", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quad_enc_emu.md
QUAD_ENC_EMU -- requirements
Module: quad_enc_emu

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 4, giving clocks between successive quadrature edges (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port load  input  1  request to move to bcd_target; sampled each clk.
REQ-005 The block SHALL have port bcd_target  input  8  target position, two BCD digits, [7:4] tens and [3:0] units.
REQ-006 The block SHALL have port a  output  1  quadrature channel A.
REQ-007 The block SHALL have port b  output  1  quadrature channel B.
REQ-008 The block SHALL have port bcd_pos  output  8  current emulated position, two BCD digits.
REQ-009 The block SHALL have port busy  output  1  high while a move is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a move completes.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-012 The block SHALL use an FSM with states IDLE, RUN and FIN.
REQ-013 In IDLE, the block SHALL accept a load only when load=1; while busy=1, load SHALL be ignored with no retarget and no err.
REQ-014 On an accepted load, if either digit of bcd_target exceeds 9, the block SHALL pulse err the next cycle and change no other state.
REQ-015 On an accepted load with a valid target equal to bcd_pos, the block SHALL go to FIN, produce no a/b edges and pulse done the next cycle.
REQ-016 Otherwise the block SHALL latch the target and direction, clear the divider, enter RUN and set busy=1 from the next cycle.
REQ-017 In RUN, one quadrature edge SHALL occur every STEP_DIV clocks; the first edge SHALL occur STEP_DIV cycles after the accept edge.
REQ-018 CW edges SHALL follow the {a,b} sequence 00->10->11->01->00 (A leads B); CCW edges SHALL follow the reverse sequence (B leads A).
REQ-019 Four edges SHALL make one detent; bcd_pos SHALL change by +1 (CW) or -1 (CCW) in BCD on the same clock as the fourth edge, so {a,b} is 00 at every detent.
REQ-020 bcd_pos arithmetic SHALL be BCD: the units digit wraps 9->0 with carry into tens, and 0->9 with borrow from tens.
REQ-021 When bcd_pos reaches the latched target, the FSM SHALL enter FIN; in the following cycle busy SHALL be 0, done SHALL be 1, and the FSM SHALL return to IDLE.
REQ-022 A move of N detents SHALL take exactly 4*N*STEP_DIV clocks from the accept edge to the final edge.
REQ-023 Outside RUN, a and b SHALL hold their values.

Reset
REQ-024 While reset_n=0, the block SHALL asynchronously force a=0, b=0, bcd_pos=8'h00, busy=0, done=0, err=0, FSM=IDLE and divider=0.
REQ-025 A reset during RUN SHALL abort the move; no done pulse SHALL follow.
REQ-026 After reset_n deasserts, the block SHALL accept a load on the first rising clk edge.

Configuration
REQ-027 With ENC_WRAP_EN defined, the block SHALL take the shorter modulo-100 path, with 99->00 and 00->99 wrap; a tie (distance 50) SHALL go CW.
REQ-028 With ENC_WRAP_EN undefined, the block SHALL move CW if target > bcd_pos and CCW otherwise, and bcd_pos SHALL never wrap.

Verification
REQ-029 The bench SHALL cover, with STEP_DIV=2 after reset: load 8'h03 -> 12 CW edges every 2 clocks; bcd_pos 01,02,03 on the 4th, 8th and 12th edges; done 25 cycles after the accept edge.
REQ-030 The bench SHALL cover: from pos 03, load 8'h00 -> 12 CCW edges with B leading A; bcd_pos 02,01,00; done pulse once.
REQ-031 The bench SHALL cover: load 8'h1A -> err pulse 1 cycle; no a/b edges; bcd_pos unchanged; busy stays 0.
REQ-032 The bench SHALL cover: from pos 00, load 8'h98 -> with ENC_WRAP_EN, 8 CCW edges and bcd_pos 99 then 98; without ENC_WRAP_EN, 392 CW edges ending at 98.
REQ-033 The bench SHALL cover: load 8'h05 with bcd_pos=05 -> done next cycle, busy never 1, no edges.
REQ-034 The bench SHALL cover: a second load during a move is ignored, then reset_n low mid-move -> a=b=0, bcd_pos=00 and busy=0 without waiting for clk, and no done pulse.
